// File: rtl/draw_sprite_blit.sv
// draw_sprite_blit: streams a SPR_W x SPR_H sprite from a synchronous ROM to the VGA pixel-write port
module draw_sprite_blit #(
  parameter int SPR_W     = 64,
  parameter int SPR_H     = 64,
  parameter int ADDR_W    = 12,
  parameter int X_W       = 9,
  parameter int Y_W       = 8,
  parameter int COLOR_W   = 12,
  parameter int ROM_LAT   = 1,
  parameter int SCREEN_W  = 320,
  parameter int SCREEN_H  = 240,
  parameter int KEY_EN    = 1,
  parameter int KEY_COLOR = 0
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic               abort,
  input  logic [X_W-1:0]     x_pos,
  input  logic [Y_W-1:0]     y_pos,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [COLOR_W-1:0] rom_q,
  output logic [X_W-1:0]     x_out,
  output logic [Y_W-1:0]     y_out,
  output logic [COLOR_W-1:0] color_out,
  output logic               write_en,
  output logic               busy,
  output logic               done
);
  localparam int CW = $clog2(SPR_W);
  localparam int RW = SPR_H > 1 ? $clog2(SPR_H) : 1;
  typedef enum logic [1:0] {IDLE, ISSUE, FLUSH, DONE} state_t;
  state_t r_state, w_next;
  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic [X_W-1:0] r_x_base;
  logic [Y_W-1:0] r_y_base;
  logic [1:0] r_cnt;
  logic r_pv [ROM_LAT];
  logic [CW-1:0] r_pc [ROM_LAT];
  logic [RW-1:0] r_pr [ROM_LAT];
  logic w_col_end, w_last, w_kill, w_clip, w_key, w_out_v;
  logic [X_W:0] w_x;
  logic [Y_W:0] w_y;
  assign w_col_end = r_col == CW'(SPR_W - 1);
  assign w_last = w_col_end && r_row == RW'(SPR_H - 1);
  assign w_kill = abort && r_state != IDLE;
  assign rom_addr = ADDR_W'(r_row) * ADDR_W'(SPR_W) + ADDR_W'(r_col);
  assign w_out_v = r_pv[ROM_LAT-1] && !w_kill;
  // coordinates are formed one bit wider so a wrap past the screen width clips instead of wrapping
  assign w_x = {1'b0, r_x_base} + (X_W+1)'(r_pc[ROM_LAT-1]);
  assign w_y = {1'b0, r_y_base} + (Y_W+1)'(r_pr[ROM_LAT-1]);
  assign w_clip = w_x >= (X_W+1)'(SCREEN_W) || w_y >= (Y_W+1)'(SCREEN_H);
  assign w_key = KEY_EN != 0 && rom_q == COLOR_W'(KEY_COLOR);
  assign busy = r_state != IDLE;
  assign done = r_state == DONE;
  // state register
  always_ff @(posedge clk) begin
    if (!resetn) r_state <= IDLE;
    else r_state <= w_next;
  end
  // next state; abort outranks every other transition but is ignored in IDLE
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = start ? ISSUE : IDLE;
      ISSUE:   w_next = w_last ? FLUSH : ISSUE;
      FLUSH:   w_next = r_cnt == 2'(ROM_LAT) ? DONE : FLUSH;
      default: w_next = IDLE;
    endcase
    if (w_kill) w_next = IDLE;
  end
  // position latch, raster counters and flush counter
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_col <= '0;
      r_row <= '0;
      r_x_base <= '0;
      r_y_base <= '0;
      r_cnt <= '0;
    end else begin
      if (r_state == IDLE && start) begin
        r_x_base <= x_pos;
        r_y_base <= y_pos;
        r_col <= '0;
        r_row <= '0;
      end else if (r_state == ISSUE && !abort) begin
        r_col <= w_col_end ? '0 : r_col + 1'b1;
        if (w_col_end) r_row <= w_last ? '0 : r_row + 1'b1;
      end
      r_cnt <= r_state == FLUSH ? r_cnt + 1'b1 : '0;
    end
  end
  // pipeline carrying (valid,col,row) alongside the ROM read latency
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < ROM_LAT; i++) begin
        r_pv[i] <= 1'b0;
        r_pc[i] <= '0;
        r_pr[i] <= '0;
      end
    end else begin
      r_pv[0] <= r_state == ISSUE && !abort;
      r_pc[0] <= r_col;
      r_pr[0] <= r_row;
      for (int i = 1; i < ROM_LAT; i++) begin
        r_pv[i] <= r_pv[i-1];
        r_pc[i] <= r_pc[i-1];
        r_pr[i] <= r_pr[i-1];
      end
      if (w_kill) for (int i = 0; i < ROM_LAT; i++) r_pv[i] <= 1'b0;
    end
  end
  // output stage pairs rom_q with its pipeline entry; coordinates/colour hold between valid pixels
  always_ff @(posedge clk) begin
    if (!resetn) begin
      x_out <= '0;
      y_out <= '0;
      color_out <= '0;
      write_en <= 1'b0;
    end else begin
      write_en <= w_out_v && !w_clip && !w_key;
      if (w_out_v) begin
        x_out <= w_x[X_W-1:0];
        y_out <= w_y[Y_W-1:0];
        color_out <= rom_q;
      end
    end
  end
endmodule

// File: tb/tb_draw_sprite_blit.sv
// tb_draw_sprite_blit: scoreboard bench for the sprite blitter on a 4x2 sprite, ROM latency 1 and 3
module tb_draw_sprite_blit;
  localparam int N = 8;
  typedef struct {int x; int y; int c; int k;} pix_t;
  logic clk = 0;
  logic resetn = 0;
  logic abort = 0;
  logic start [3];
  logic [8:0] x_pos = 0;
  logic [7:0] y_pos = 0;
  logic [11:0] ra [3];
  logic [11:0] q [3];
  logic [8:0] xo [3];
  logic [7:0] yo [3];
  logic [11:0] co [3];
  logic we [3];
  logic bz [3];
  logic dn [3];
  logic [11:0] mem [8];
  logic [11:0] d3a, d3b;
  int n_chk = 0;
  int n_fail = 0;
  pix_t sb [$];

  always #5 clk = ~clk;

  // ROM models: latency 1 for instances 0/1, latency 3 for instance 2
  always @(posedge clk) begin
    q[0] <= mem[ra[0][2:0]];
    q[1] <= mem[ra[1][2:0]];
    d3a <= mem[ra[2][2:0]];
    d3b <= d3a;
    q[2] <= d3b;
  end

  draw_sprite_blit #(.SPR_W(4), .SPR_H(2), .ROM_LAT(1), .KEY_EN(0)) u_plain (
    .clk(clk), .resetn(resetn), .start(start[0]), .abort(abort), .x_pos(x_pos), .y_pos(y_pos),
    .rom_addr(ra[0]), .rom_q(q[0]), .x_out(xo[0]), .y_out(yo[0]), .color_out(co[0]),
    .write_en(we[0]), .busy(bz[0]), .done(dn[0]));
  draw_sprite_blit #(.SPR_W(4), .SPR_H(2), .ROM_LAT(1), .KEY_EN(1)) u_key (
    .clk(clk), .resetn(resetn), .start(start[1]), .abort(abort), .x_pos(x_pos), .y_pos(y_pos),
    .rom_addr(ra[1]), .rom_q(q[1]), .x_out(xo[1]), .y_out(yo[1]), .color_out(co[1]),
    .write_en(we[1]), .busy(bz[1]), .done(dn[1]));
  draw_sprite_blit #(.SPR_W(4), .SPR_H(2), .ROM_LAT(3), .KEY_EN(1)) u_lat3 (
    .clk(clk), .resetn(resetn), .start(start[2]), .abort(abort), .x_pos(x_pos), .y_pos(y_pos),
    .rom_addr(ra[2]), .rom_q(q[2]), .x_out(xo[2]), .y_out(yo[2]), .color_out(co[2]),
    .write_en(we[2]), .busy(bz[2]), .done(dn[2]));

  function automatic int lat_of(input int i);
    return i == 2 ? 3 : 1;
  endfunction

  // one blit on instance i; k counts sample points from the first ISSUE cycle (k=0)
  // kill_k >= 0 asserts abort (or resetn=0 when is_rst) during sample cycle kill_k
  task automatic run_blit(input int i, input int xb, input int yb, input int kill_k, input bit is_rst);
    int lat = lat_of(i);
    int dk = N + lat + 1;
    int last = kill_k < 0 ? dk + 2 : kill_k + 4;
    pix_t p;
    sb.delete();
    for (int n = 0; n < N; n++) begin
      p.x = xb + n % 4;
      p.y = yb + n / 4;
      p.c = int'(mem[n]);
      p.k = n + lat + 1;
      if (p.x < 320 && p.y < 240 && !(i != 0 && p.c == 0) && (kill_k < 0 || p.k <= kill_k)) sb.push_back(p);
    end
    @(negedge clk);
    x_pos = 9'(xb);
    y_pos = 8'(yb);
    start[i] = 1;
    @(negedge clk);
    start[i] = 0;
    x_pos = 9'd3;
    y_pos = 8'd4;
    n_chk++;
    if (bz[i] !== 1'b1 || ra[i] !== 12'd0) begin
      n_fail++;
      $display("FAIL first_issue[%0d]: busy=%b rom_addr=%0d, want busy=1 rom_addr=0", i, bz[i], ra[i]);
    end
    for (int k = 0; k <= last; k++) begin
      if (we[i] === 1'b1) begin
        n_chk++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL extra_write[%0d]: k=%0d got (%0d,%0d) color %0h, want no write", i, k, xo[i], yo[i], co[i]);
        end else begin
          p = sb.pop_front();
          if (xo[i] !== 9'(p.x) || yo[i] !== 8'(p.y) || co[i] !== 12'(p.c) || k != p.k) begin
            n_fail++;
            $display("FAIL pixel[%0d]: got (%0d,%0d) color %0h at k=%0d, want (%0d,%0d) color %0h at k=%0d",
                     i, xo[i], yo[i], co[i], k, p.x, p.y, p.c, p.k);
          end
        end
      end else if (we[i] !== 1'b0) begin
        n_chk++;
        n_fail++;
        $display("FAIL write_en_x[%0d]: k=%0d got %b, want 0 or 1", i, k, we[i]);
      end
      n_chk++;
      if (dn[i] !== (kill_k < 0 && k == dk)) begin
        n_fail++;
        $display("FAIL done[%0d]: k=%0d got %b, want %b", i, k, dn[i], kill_k < 0 && k == dk);
      end
      if (kill_k < 0 && k == dk + 1) begin
        n_chk++;
        if (bz[i] !== 1'b0) begin
          n_fail++;
          $display("FAIL busy_after_done[%0d]: got %b, want 0", i, bz[i]);
        end
      end
      if (kill_k >= 0 && k == kill_k + 1) begin
        n_chk++;
        if (is_rst && (xo[i] !== 0 || yo[i] !== 0 || co[i] !== 0 || we[i] !== 0 || bz[i] !== 0 || dn[i] !== 0 || ra[i] !== 0)) begin
          n_fail++;
          $display("FAIL reset_outputs[%0d]: got x=%0d y=%0d c=%0h we=%b busy=%b done=%b addr=%0d, want all 0",
                   i, xo[i], yo[i], co[i], we[i], bz[i], dn[i], ra[i]);
        end else if (!is_rst && bz[i] !== 1'b0) begin
          n_fail++;
          $display("FAIL abort_busy[%0d]: got %b, want 0", i, bz[i]);
        end
        abort = 0;
        resetn = 1;
      end
      if (k == kill_k) begin
        if (is_rst) resetn = 0;
        else abort = 1;
      end
      @(negedge clk);
    end
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL missing_writes[%0d]: got %0d unwritten pixels, want 0", i, sb.size());
    end
  endtask

  task automatic test_reset;
    resetn = 0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if (xo[i] !== 0 || yo[i] !== 0 || co[i] !== 0 || we[i] !== 0 || bz[i] !== 0 || dn[i] !== 0 || ra[i] !== 0) begin
        n_fail++;
        $display("FAIL reset[%0d]: got x=%0d y=%0d c=%0h we=%b busy=%b done=%b addr=%0d, want all 0",
                 i, xo[i], yo[i], co[i], we[i], bz[i], dn[i], ra[i]);
      end
    end
    resetn = 1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    run_blit(0, 10, 20, -1, 0);
  endtask

  task automatic test_color_key;
    mem[2] = 12'h000;
    mem[5] = 12'h000;
    run_blit(1, 10, 20, -1, 0);
    run_blit(0, 10, 20, -1, 0);
    for (int n = 0; n < N; n++) mem[n] = 12'(n + 1);
  endtask

  task automatic test_clipping;
    run_blit(0, 318, 239, -1, 0);
    run_blit(1, 510, 5, -1, 0);
    run_blit(0, 316, 0, -1, 0);
  endtask

  task automatic test_latency;
    run_blit(2, 10, 20, -1, 0);
  endtask

  task automatic test_abort;
    run_blit(0, 10, 20, 2, 0);
    run_blit(2, 40, 60, 5, 0);
  endtask

  task automatic test_reset_mid;
    run_blit(0, 10, 20, 8, 1);
    run_blit(0, 10, 20, -1, 0);
  endtask

  task automatic test_back_to_back;
    bit seen = 0;
    @(negedge clk);
    x_pos = 9'd100;
    y_pos = 8'd50;
    start[0] = 1;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      seen = dn[0];
    end
    n_chk++;
    if (!seen) begin
      n_fail++;
      $display("FAIL b2b_done: got no done within 40 cycles, want done");
    end
    @(negedge clk);
    n_chk++;
    if (bz[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_idle: got busy=%b, want 0", bz[0]);
    end
    @(negedge clk);
    n_chk++;
    if (bz[0] !== 1'b1 || ra[0] !== 12'd0) begin
      n_fail++;
      $display("FAIL b2b_restart: got busy=%b addr=%0d, want busy=1 addr=0", bz[0], ra[0]);
    end
    start[0] = 0;
    abort = 1;
    @(negedge clk);
    abort = 0;
    n_chk++;
    if (bz[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_abort: got busy=%b, want 0", bz[0]);
    end
    repeat (4) @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) start[i] = 0;
    for (int n = 0; n < N; n++) mem[n] = 12'(n + 1);
    test_reset;
    test_basic;
    test_color_key;
    test_clipping;
    test_latency;
    test_abort;
    test_reset_mid;
    test_back_to_back;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
